namuru_time_base: RTL

Sample-strobe-driven time base for the Namuru GPS correlator. Consumes the programmed `tic_divide` / `accum_divide` periods from the control interface and produces the TIC and accumulation-interrupt strobes, the aligned per-sample enable, and the live countdown values that the control interface returns as `tic_count` / `accum_count`. Sits directly downstream of the control interface's timing registers and upstream of its status/interrupt logic and the tracking channels.

---
 rtl/namuru_time_base.sv | 82 ++++++++
 1 files changed

// File: rtl/namuru_time_base.sv
// ============================================================================
// namuru_time_base : sample-strobe-driven TIC / accumulation time base
// Revision: 1.0
// ============================================================================
`default_nettype none

module namuru_time_base #(
  parameter int DIV_W = 24
) (
  input  logic             sys_clk,
  input  logic             rstn,
  input  logic             sample_en,
  input  logic [DIV_W-1:0] tic_divide,
  input  logic [DIV_W-1:0] accum_divide,
  output logic             pre_tic_enable,
  output logic             tic_enable,
  output logic             accum_enable,
  output logic             accum_sample_enable,
  output logic [DIV_W-1:0] tic_count,
  output logic [DIV_W-1:0] accum_count
);

  logic [DIV_W-1:0] w_cnt  [2];
  logic             w_fire [2];
  logic             r_tic_enable;
  logic             r_sample_enable;

  // Unit 0 is the TIC counter, unit 1 the accumulation counter.
  for (genvar u = 0; u < 2; u++) begin : g_unit
    logic [DIV_W-1:0] w_divide;
    logic [DIV_W-1:0] r_cnt;
    logic             r_armed;
    logic             r_fire;

    assign w_divide = (u == 0) ? tic_divide : accum_divide;

    // Divide is only sampled at arming and reload so periods are never cut short.
    always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
        r_cnt   <= '0;
        r_armed <= 1'b0;
        r_fire  <= 1'b0;
      end else begin
        r_fire <= 1'b0;
        if (sample_en) begin
          if (!r_armed) begin
            r_cnt   <= w_divide;
            r_armed <= 1'b1;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_fire <= 1'b1;
            r_cnt  <= w_divide;
          end
        end
      end
    end

    assign w_cnt[u]  = r_cnt;
    assign w_fire[u] = r_fire;
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      r_tic_enable    <= 1'b0;
      r_sample_enable <= 1'b0;
    end else begin
      r_tic_enable    <= w_fire[0];
      r_sample_enable <= sample_en;
    end
  end

  assign pre_tic_enable      = w_fire[0];
  assign tic_enable          = r_tic_enable;
  assign accum_enable        = w_fire[1];
  assign accum_sample_enable = r_sample_enable;
  assign tic_count           = w_cnt[0];
  assign accum_count         = w_cnt[1];

endmodule

`default_nettype wire
